croc_board_io: RTL

// Parametrised board-I/O conditioner between FPGA pads/VIO and croc_soc. Synchronises
// and debounces GpioCount switch inputs plus fetch-enable, reports per-channel edge

---
 rtl/croc_board_io.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/croc_board_io.sv
// Board-I/O conditioner for croc_soc. Synchronises and debounces the GPIO
// switches and the fetch-enable switch, reports debounced edges, applies
// output-enable gating between pads and SoC, and divides soc_clk into the
// RTC/reference clock. Everything is clocked by clk_i.
module croc_board_io #(
  parameter int unsigned GpioCount      = 4,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 20000,
  parameter int unsigned RtcDiv         = 610
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GpioCount-1:0] gpio_pad_i,
  input  logic [GpioCount-1:0] vio_gpio_i,
  input  logic                 fetch_en_pad_i,
  input  logic                 vio_fetch_en_i,
  input  logic [GpioCount-1:0] soc_gpio_o_i,
  input  logic [GpioCount-1:0] soc_gpio_out_en_i,
  output logic [GpioCount-1:0] soc_gpio_i_o,
  output logic [GpioCount-1:0] gpio_pad_o,
  output logic [GpioCount-1:0] gpio_rise_o,
  output logic [GpioCount-1:0] gpio_fall_o,
  output logic                 fetch_en_o,
  output logic                 rtc_clk_o
);

  // Channels 0..GpioCount-1 are the GPIO switches; the top channel is fetch-enable.
  localparam int unsigned NumCh = GpioCount + 1;
  localparam int unsigned CntW  = $clog2(DebounceCycles + 1);
  localparam int unsigned RcntW = $clog2(RtcDiv + 1);

  // Counter value on which a persisting new level is accepted.
  localparam logic [CntW-1:0]  CntLast  = CntW'(DebounceCycles - 1);
  localparam logic [RcntW-1:0] RcntLast = RcntW'(RtcDiv);

  // Raw asynchronous inputs gathered into one channel vector.
  logic [NumCh-1:0] raw_ch;
  assign raw_ch = {fetch_en_pad_i, gpio_pad_i};

  // Synchroniser chains: stage 0 samples the pad, the last stage feeds the debouncer.
  logic [SyncStages-1:0][NumCh-1:0] sync_q, sync_d;
  logic [NumCh-1:0]                 sync_out;

  // Debounce state per channel.
  logic [NumCh-1:0]           stable_q, stable_d;
  logic [NumCh-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumCh-1:0]           upd;

  // Registered edge pulses for the GPIO channels only.
  logic [GpioCount-1:0] rise_q, rise_d;
  logic [GpioCount-1:0] fall_q, fall_d;

  // RTC divider state.
  logic [RcntW-1:0] rcnt_q, rcnt_d;
  logic             rtc_q, rtc_d;

  // Shift each synchroniser chain by one stage.
  always_comb begin
    sync_d[0] = raw_ch;
    for (int s = 1; s < SyncStages; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SyncStages-1];

  // Count consecutive cycles the synchronised level disagrees with the accepted level.
  always_comb begin
    // NOTE: every variable gets a default before the branches, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    upd   = '0;
    for (int ch = 0; ch < NumCh; ch++) begin
      if (sync_out[ch] == stable_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CntLast) begin
        upd[ch]   = 1'b1;
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CntW'(1);
      end
    end
    // An update only happens when the levels differ, so accepting is a toggle.
    stable_d = stable_q ^ upd;
  end

  // Turn accepted level changes into rise/fall pulses for the GPIO channels.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int ch = 0; ch < GpioCount; ch++) begin
      rise_d[ch] = upd[ch] & sync_out[ch];
      fall_d[ch] = upd[ch] & ~sync_out[ch];
    end
  end

  // RTC divider: wrap at RtcDiv and toggle the output on the wrap.
  always_comb begin
    if (rcnt_q == RcntLast) begin
      rcnt_d = '0;
      rtc_d  = ~rtc_q;
    end else begin
      rcnt_d = rcnt_q + RcntW'(1);
      rtc_d  = rtc_q;
    end
  end

  // All state registers, cleared asynchronously by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the synchroniser and counter arrays are ordinary flops, not a
      // RAM, so they are reset like any other register.
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      rcnt_q   <= '0;
      rtc_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rcnt_q   <= rcnt_d;
      rtc_q    <= rtc_d;
    end
  end

  // Output gating: a pin driven by the SoC is not also read back as an input.
  assign soc_gpio_i_o = ~soc_gpio_out_en_i & (stable_q[GpioCount-1:0] | vio_gpio_i);
  assign gpio_pad_o   = soc_gpio_out_en_i & soc_gpio_o_i;
  assign fetch_en_o   = stable_q[GpioCount] | vio_fetch_en_i;
  assign gpio_rise_o  = rise_q;
  assign gpio_fall_o  = fall_q;
  assign rtc_clk_o    = rtc_q;

endmodule
